// File: rtl/rv32i_types.sv
// Shared types for the rv32i pipeline slice.
//   dmem_rsp_state_t : state encoding of the data-memory responder FSM
//   DMEM_LFSR_SEED   : reset value of the responder's latency-jitter LFSR
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_rsp_state_t;

  localparam logic [15:0] DMEM_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/dmem_array.sv
// MEM_WORDS x 32 single-port data array with per-byte write enables.
// The read port is sampled on the same edge as the write, so rdata holds
// the word as it was before that edge's write (read-before-write).
// Ports:
//   clk, rst   : clock, async active-low reset (read register only)
//   en         : access strobe; read and optional byte writes this edge
//   idx        : word index
//   wmask      : per-byte write enables
//   wdata      : write data, byte lanes aligned to the word
//   rdata      : registered pre-write read word
module dmem_array #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [AW-1:0] idx,
  input  logic [3:0]    wmask,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // Contents are deliberately not reset.
  logic [3:0][7:0] mem [MEM_WORDS];

  for (genvar b = 0; b < 4; b++) begin : g_lane
    always_ff @(posedge clk) begin
      if (en && wmask[b]) mem[idx][b] <= wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (en) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage dmem interface. Accepts one
// word-aligned request at a time, performs the access at acceptance
// (read-before-write), and returns a one-cycle dmem_resp pulse LATENCY
// cycles later with the read word masked by the captured rmask.
// Optional build macro DMEM_RAND_LAT_EN adds 0..3 extra wait cycles per
// request from a 16-bit Fibonacci LFSR (repeatable from reset).
// Ports:
//   clk, rst                : clock, async active-low reset
//   dmem_need               : request valid, held until dmem_resp
//   dmem_addr               : byte address; word index from addr[AW+1:2]
//   dmem_rmask, dmem_wmask  : byte read / write enables
//   dmem_wdata              : write data
//   dmem_rdata              : read data, updated on entry to RESP, then held
//   dmem_resp               : single-cycle response pulse
module dmem_responder
  import rv32i_types::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_need,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp
);

  localparam int AW = $clog2(MEM_WORDS);
`ifdef DMEM_RAND_LAT_EN
  localparam int CNT_W = $clog2(LATENCY + 4);
`else
  localparam int CNT_W = $clog2(LATENCY + 1);
`endif

  dmem_rsp_state_t  state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] first_cnt;
  logic [3:0]       rmask_q;
  logic [31:0]      rdata_q;
  logic [31:0]      rd_word;
  logic [31:0]      rd_masked;
  logic [1:0]       extra;
  logic             accept;

  assign accept = (state == IDLE) && dmem_need;

  dmem_array #(.MEM_WORDS(MEM_WORDS)) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (accept),
    .idx   (dmem_addr[AW+1:2]),
    .wmask (dmem_wmask),
    .wdata (dmem_wdata),
    .rdata (rd_word)
  );

`ifdef DMEM_RAND_LAT_EN
  // Taps 16,14,13,11; the pre-advance value sets this request's jitter.
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        lfsr <= DMEM_LFSR_SEED;
    else if (accept) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign extra = lfsr[1:0];
`else
  assign extra = 2'd0;
`endif

  // Counter holds the remaining cycles before RESP; zero means go straight there.
  assign first_cnt = CNT_W'(LATENCY - 1) + CNT_W'(extra);

  always_comb begin
    rd_masked = '0;
    for (int b = 0; b < 4; b++)
      rd_masked[8*b +: 8] = rd_word[8*b +: 8] & {8{rmask_q[b]}};
  end

  // The read word only lands in rd_word at the capture edge, so in RESP the
  // output comes straight from the masked word; rdata_q holds it afterwards.
  // This keeps LATENCY=1 working while dmem_rdata still changes only on
  // entry to RESP.
  assign dmem_rdata = (state == RESP) ? rd_masked : rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dmem_resp <= 1'b0;
      rmask_q   <= '0;
      rdata_q   <= '0;
    end else begin
      dmem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (dmem_need) begin
            rmask_q <= dmem_rmask;
            cnt     <= first_cnt;
            if (first_cnt == '0) begin
              state     <= RESP;
              dmem_resp <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt <= CNT_W'(1)) begin
            state     <= RESP;
            dmem_resp <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          rdata_q <= rd_masked;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int LATENCY = 2;
`ifdef DMEM_RAND_LAT_EN
  localparam int LMAX = LATENCY + 3;
`else
  localparam int LMAX = LATENCY;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dmem_need = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [3:0]  dmem_rmask = '0;
  logic [3:0]  dmem_wmask = '0;
  logic [31:0] dmem_wdata = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  int total = 0;
  int bad   = 0;
  logic [31:0] prev_rdata = '0;

  always #5 clk = ~clk;

  dmem_responder #(.MEM_WORDS(1024), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .dmem_need(dmem_need), .dmem_addr(dmem_addr),
    .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge one cycle after the response.
  task automatic do_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, input logic [31:0] exp, output int lat);
    bit seen = 0;
    lat = -1;
    dmem_need = 1; dmem_addr = a; dmem_rmask = rm; dmem_wmask = wm; dmem_wdata = wd;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(posedge clk); @(negedge clk);
      if (dmem_resp) begin
        seen = 1; lat = k;
      end else begin
        chk("rdata_stable", dmem_rdata, prev_rdata);
      end
    end
    dmem_need = 0;
    total++;
    if (!seen || lat < LATENCY || lat > LMAX) begin
      bad++;
      $display("FAIL latency addr=%h: got %0d want %0d..%0d", a, lat, LATENCY, LMAX);
    end
    if (seen) begin
      chk("rdata", dmem_rdata, exp);
      prev_rdata = exp;
      @(posedge clk); @(negedge clk);
      chk("resp_pulse_once", {31'b0, dmem_resp}, 32'd0);
      chk("rdata_hold", dmem_rdata, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 0;
    @(negedge clk); @(negedge clk);
    rst = 1;
    prev_rdata = '0;
  endtask

  initial begin
    int lat;
    vecs[0]  = '{32'h100,  4'h0,    4'hF,    32'hDEADBEEF, 32'h0};
    vecs[1]  = '{32'h100,  4'hF,    4'h0,    32'h0,        32'hDEADBEEF};
    vecs[2]  = '{32'h200,  4'h0,    4'hF,    32'h11223344, 32'h0};
    vecs[3]  = '{32'h202,  4'hF,    4'b0100, 32'h00AA0000, 32'h11223344}; // pre-write data
    vecs[4]  = '{32'h200,  4'hF,    4'h0,    32'h0,        32'h11AA3344};
    vecs[5]  = '{32'h200,  4'b0011, 4'h0,    32'h0,        32'h00003344};
    vecs[6]  = '{32'h100,  4'h0,    4'h0,    32'hFFFFFFFF, 32'h0};         // no-op access
    vecs[7]  = '{32'h100,  4'hF,    4'h0,    32'h0,        32'hDEADBEEF};
    vecs[8]  = '{32'h1100, 4'hF,    4'h0,    32'h0,        32'hDEADBEEF}; // aliases 0x100
    vecs[9]  = '{32'h104,  4'h0,    4'b1001, 32'hAABBCCDD, 32'h0};
    vecs[10] = '{32'h107,  4'b1001, 4'h0,    32'h0,        32'hAA0000DD};

    // reset + idle
    @(negedge clk); @(negedge clk);
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      chk("idle_resp", {31'b0, dmem_resp}, 32'd0);
      chk("idle_rdata", dmem_rdata, 32'd0);
    end

    foreach (vecs[i])
      do_req(vecs[i].addr, vecs[i].rmask, vecs[i].wmask, vecs[i].wdata, vecs[i].exp, lat);

`ifndef DMEM_RAND_LAT_EN
    // need held high: one pulse every LATENCY+1 cycles
    dmem_need = 1; dmem_addr = 32'h100; dmem_rmask = 4'hF; dmem_wmask = 4'h0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("b2b_resp_c%0d", c), {31'b0, dmem_resp}, {31'b0, (c % 3) == 2});
      if (dmem_resp) chk("b2b_rdata", dmem_rdata, 32'hDEADBEEF);
    end
    dmem_need = 0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("b2b_drained", {31'b0, dmem_resp}, 32'd0);
    prev_rdata = 32'hDEADBEEF;
`endif

    // reset during WAIT: write stays committed, response dropped
    dmem_need = 1; dmem_addr = 32'h40; dmem_rmask = 4'h0; dmem_wmask = 4'hF; dmem_wdata = 32'h5;
    @(posedge clk); @(negedge clk);
    rst = 0; dmem_need = 0;
    @(negedge clk);
    rst = 1;
    prev_rdata = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      chk("rst_no_resp", {31'b0, dmem_resp}, 32'd0);
      chk("rst_rdata", dmem_rdata, 32'd0);
    end
    do_req(32'h40, 4'hF, 4'h0, 32'h0, 32'h5, lat);

`ifdef DMEM_RAND_LAT_EN
    begin
      int seq1[100];
      int seq2[100];
      pulse_reset();
      for (int i = 0; i < 100; i++) begin
        do_req(32'(i * 4), 4'h0, 4'h0, 32'h0, 32'h0, lat);
        seq1[i] = lat;
      end
      pulse_reset();
      for (int i = 0; i < 100; i++) begin
        do_req(32'(i * 4), 4'h0, 4'h0, 32'h0, 32'h0, lat);
        seq2[i] = lat;
        chk($sformatf("rand_repeat_%0d", i), 32'(seq2[i]), 32'(seq1[i]));
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
